csr_bank: RTL and testbench

Machine-mode CSR bank for the pipelined core, successor to the fixed 16-entry CSR array. Decodes real 12-bit CSR addresses and provides atomic write/set/clear, WARL field masking, and 64-bit-capable cycle/instret/HPM counters with `mcountinhibit`. It performs trap entry and `mret` state updates and raises an interrupt-pending indication to the control unit. It sits beside the register file: it is read in Execute and written at Writeback/commit.

---
 rtl/csr_bank.sv | 224 ++++++++++++++++++++++
 tb/tb_csr_bank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_bank.sv
// csr_bank: machine-mode CSR bank. Decodes 12-bit CSR addresses and serves
// combinational reads in Execute. It applies write/set/clear at commit,
// maintains the cycle/instret/HPM counters, and updates mstatus and the trap
// CSRs on trap entry and mret.
module csr_bank #(
  parameter int          COUNTER_WIDTH = 64,
  parameter int          NUM_HPM       = 4,
  parameter int          RETIRE_WIDTH  = 2,
  parameter logic [31:0] MISA_VALUE    = 32'h40000100,
  parameter logic [31:0] TRAP_VECTOR   = 32'h0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [11:0]                       csrReadAddress,
  output logic [31:0]                       csrReadData,
  output logic                              csrIllegal,
  input  logic [1:0]                        csrWriteOp,
  input  logic [11:0]                       csrWriteAddress,
  input  logic [31:0]                       csrWriteData,
  input  logic [$clog2(RETIRE_WIDTH+1)-1:0] retireCount,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpmEvent,
  input  logic                              trapEnable,
  input  logic [31:0]                       trapCause,
  input  logic [31:0]                       trapPC,
  input  logic [31:0]                       trapValue,
  input  logic                              mretEnable,
  input  logic                              externalInterrupt,
  input  logic                              timerInterrupt,
  output logic                              interruptPending,
  output logic [31:0]                       mtvecOut,
  output logic [31:0]                       mepcOut
);

  localparam int HPM_SLOTS = (NUM_HPM > 0) ? NUM_HPM : 1;
  // Writable mcountinhibit bits: CY (0), IR (2) and one per implemented HPM counter.
  localparam logic [31:0] INHIBIT_MASK =
    32'h5 | 32'((((64'd1 << NUM_HPM) - 64'd1) << 3));

  typedef struct packed {
    logic        ok;
    logic [31:0] data;
  } rd_t;

  // Architectural state
  logic                     mstatus_mie, mstatus_mpie;
  logic                     mie_meie, mie_mtie;
  logic [31:0]              mtvec, mscratch, mepc, mcause, mtval, mcountinhibit;
  logic [COUNTER_WIDTH-1:0] mcycle, minstret;
  logic [COUNTER_WIDTH-1:0] hpm [HPM_SLOTS];

  logic [31:0] mstatus_val, mie_val, mip_val;
  assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign mie_val     = {20'b0, mie_meie, 3'b0, mie_mtie, 7'b0};
  assign mip_val     = {20'b0, externalInterrupt, 3'b0, timerInterrupt, 7'b0};

  assign interruptPending = mstatus_mie &
                            ((mie_meie & externalInterrupt) | (mie_mtie & timerInterrupt));
  assign mtvecOut = mtvec;
  assign mepcOut  = mepc;

  // Selects one 32-bit half of a counter; the high half is zero-extended
  // and reads 0 when the counter is only 32 bits wide.
  function automatic logic [31:0] counter_half(input logic [COUNTER_WIDTH-1:0] c,
                                                input logic hi);
    logic [63:0] e;
    e = 64'(c);
    return hi ? e[63:32] : e[31:0];
  endfunction

  // Next counter value: a software write to one half replaces that half and
  // suppresses the increment; otherwise add the increment modulo 2^COUNTER_WIDTH.
  function automatic logic [COUNTER_WIDTH-1:0] counter_next(
    input logic [COUNTER_WIDTH-1:0] c,
    input logic                     wr,
    input logic                     hi,
    input logic [31:0]              value,
    input logic [31:0]              inc
  );
    logic [63:0] e;
    e = 64'(c);
    if (wr && !hi)
      e[31:0] = value;
    else if (wr && hi && (COUNTER_WIDTH > 32))
      e[63:32] = value;
    else
      e = e + 64'(inc);
    return e[COUNTER_WIDTH-1:0];
  endfunction

  // Address decode shared by the read port and the read-modify-write path.
  function automatic rd_t read_csr(input logic [11:0] addr);
    rd_t r;
    r.ok   = 1'b1;
    r.data = 32'h0;
    case (addr)
      12'h300: r.data = mstatus_val;
      12'h301: r.data = MISA_VALUE;
      12'h304: r.data = mie_val;
      12'h305: r.data = mtvec;
      12'h320: r.data = mcountinhibit;
      12'h340: r.data = mscratch;
      12'h341: r.data = mepc;
      12'h342: r.data = mcause;
      12'h343: r.data = mtval;
      12'h344: r.data = mip_val;
      12'hF11, 12'hF12, 12'hF13, 12'hF14: r.data = 32'h0;
      default: begin
        r.ok = 1'b0;
        if (addr[11:8] == 4'hB && addr[6:5] == 2'b00) begin
          if (addr[4:0] == 5'd0) begin
            r.ok   = 1'b1;
            r.data = counter_half(mcycle, addr[7]);
          end else if (addr[4:0] == 5'd2) begin
            r.ok   = 1'b1;
            r.data = counter_half(minstret, addr[7]);
          end else begin
            for (int i = 0; i < NUM_HPM; i++) begin
              if (addr[4:0] == 5'(3 + i)) begin
                r.ok   = 1'b1;
                r.data = counter_half(hpm[i], addr[7]);
              end
            end
          end
        end
      end
    endcase
    return r;
  endfunction

  rd_t         rd_port, wr_old;
  logic        wr_ro, wr_en, cnt_wr;
  logic [31:0] wr_new;

  // Read port, illegal-access detection and read-modify-write value.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    rd_port = read_csr(csrReadAddress);
    wr_old  = read_csr(csrWriteAddress);
    wr_new  = 32'h0;
    wr_ro   = !wr_old.ok || (csrWriteAddress[11:10] == 2'b11) ||
              (csrWriteAddress == 12'h301) || (csrWriteAddress == 12'h344);
    case (csrWriteOp)
      2'b01:   wr_new = csrWriteData;
      2'b10:   wr_new = wr_old.data | csrWriteData;
      2'b11:   wr_new = wr_old.data & ~csrWriteData;
      default: wr_new = 32'h0;
    endcase
    csrReadData = rd_port.data;
    csrIllegal  = !rd_port.ok || ((csrWriteOp != 2'b00) && wr_ro);
    wr_en       = (csrWriteOp != 2'b00) && !wr_ro && !trapEnable && !mretEnable;
    cnt_wr      = wr_en && (csrWriteAddress[11:8] == 4'hB);
  end

  // Status, trap and scratch registers: trap beats mret, both beat a CSR write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      mstatus_mie   <= 1'b0;
      mstatus_mpie  <= 1'b0;
      mie_meie      <= 1'b0;
      mie_mtie      <= 1'b0;
      mtvec         <= TRAP_VECTOR;
      mscratch      <= 32'h0;
      mepc          <= 32'h0;
      mcause        <= 32'h0;
      mtval         <= 32'h0;
      mcountinhibit <= 32'h0;
    end else if (trapEnable) begin
      mepc         <= trapPC & ~32'h3;
      mcause       <= trapCause;
      mtval        <= trapValue;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mretEnable) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (wr_en) begin
      case (csrWriteAddress)
        12'h300: begin
          mstatus_mie  <= wr_new[3];
          mstatus_mpie <= wr_new[7];
        end
        12'h304: begin
          mie_meie <= wr_new[11];
          mie_mtie <= wr_new[7];
        end
        12'h305: mtvec         <= wr_new & ~32'h3;
        12'h320: mcountinhibit <= wr_new & INHIBIT_MASK;
        12'h340: mscratch      <= wr_new;
        12'h341: mepc          <= wr_new & ~32'h3;
        12'h342: mcause        <= wr_new;
        12'h343: mtval         <= wr_new;
        default: ;
      endcase
    end
  end

  // Counters: increment every edge unless inhibited or written by software.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcycle   <= '0;
      minstret <= '0;
      // NOTE: the HPM array is a handful of flops, not a RAM, so it is
      // reset like any other register.
      for (int i = 0; i < HPM_SLOTS; i++) hpm[i] <= '0;
    end else begin
      mcycle   <= counter_next(mcycle, cnt_wr && csrWriteAddress[4:0] == 5'd0,
                               csrWriteAddress[7], wr_new,
                               {31'b0, !mcountinhibit[0]});
      minstret <= counter_next(minstret, cnt_wr && csrWriteAddress[4:0] == 5'd2,
                               csrWriteAddress[7], wr_new,
                               mcountinhibit[2] ? 32'h0 : 32'(retireCount));
      for (int i = 0; i < HPM_SLOTS; i++) begin
        hpm[i] <= counter_next(hpm[i],
                               cnt_wr && (i < NUM_HPM) && csrWriteAddress[4:0] == 5'(3 + i),
                               csrWriteAddress[7], wr_new,
                               {31'b0, (i < NUM_HPM) && hpmEvent[i] && !mcountinhibit[3 + i]});
      end
    end
  end

endmodule

// File: tb/tb_csr_bank.sv
// tb_csr_bank: directed bench for csr_bank. A vector table covers the CSR
// write rules; hand-written sequences cover reset, counter half writes,
// inhibit, trap/mret and coincident-event priority.
`timescale 1ns/100ps
module tb_csr_bank;

  localparam logic [31:0] MISA_VALUE  = 32'h40000100;
  localparam logic [31:0] TRAP_VECTOR = 32'h0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] csrReadAddress = '0;
  logic [31:0] csrReadData;
  logic        csrIllegal;
  logic [1:0]  csrWriteOp = '0;
  logic [11:0] csrWriteAddress = '0;
  logic [31:0] csrWriteData = '0;
  logic [1:0]  retireCount = '0;
  logic [3:0]  hpmEvent = '0;
  logic        trapEnable = 1'b0;
  logic [31:0] trapCause = '0;
  logic [31:0] trapPC = '0;
  logic [31:0] trapValue = '0;
  logic        mretEnable = 1'b0;
  logic        externalInterrupt = 1'b0;
  logic        timerInterrupt = 1'b0;
  logic        interruptPending;
  logic [31:0] mtvecOut;
  logic [31:0] mepcOut;

  csr_bank #(
    .COUNTER_WIDTH(64), .NUM_HPM(4), .RETIRE_WIDTH(2),
    .MISA_VALUE(MISA_VALUE), .TRAP_VECTOR(TRAP_VECTOR)
  ) dut (
    .clock(clock), .reset(reset),
    .csrReadAddress(csrReadAddress), .csrReadData(csrReadData), .csrIllegal(csrIllegal),
    .csrWriteOp(csrWriteOp), .csrWriteAddress(csrWriteAddress), .csrWriteData(csrWriteData),
    .retireCount(retireCount), .hpmEvent(hpmEvent),
    .trapEnable(trapEnable), .trapCause(trapCause), .trapPC(trapPC), .trapValue(trapValue),
    .mretEnable(mretEnable), .externalInterrupt(externalInterrupt),
    .timerInterrupt(timerInterrupt), .interruptPending(interruptPending),
    .mtvecOut(mtvecOut), .mepcOut(mepcOut)
  );

  always #10 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_mcycle = '0;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic [31:0] exp_data;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
    csrReadAddress = addr;
    #1;
    check(name, csrReadData, exp);
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clock);
    #2;
    exp_mcycle = exp_mcycle + 64'd1;
  endtask

  task automatic drive_write(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data);
    csrWriteOp      = op;
    csrWriteAddress = addr;
    csrWriteData    = data;
  endtask

  initial begin
    vecs[0]  = '{2'b01, 12'h305, 32'hFFFFFFFF, 12'h305, 32'hFFFFFFFC, 1'b0};
    vecs[1]  = '{2'b10, 12'h304, 32'h00000088, 12'h304, 32'h00000080, 1'b0};
    vecs[2]  = '{2'b11, 12'h304, 32'h00000008, 12'h304, 32'h00000080, 1'b0};
    vecs[3]  = '{2'b01, 12'h340, 32'h12345678, 12'h340, 32'h12345678, 1'b0};
    vecs[4]  = '{2'b11, 12'h340, 32'h0000FF00, 12'h340, 32'h12340078, 1'b0};
    vecs[5]  = '{2'b01, 12'h341, 32'h00001003, 12'h341, 32'h00001000, 1'b0};
    vecs[6]  = '{2'b01, 12'h300, 32'hFFFFFFFF, 12'h300, 32'h00001888, 1'b0};
    vecs[7]  = '{2'b11, 12'h300, 32'h00000008, 12'h300, 32'h00001880, 1'b0};
    vecs[8]  = '{2'b01, 12'h301, 32'h00000000, 12'h301, 32'h40000100, 1'b0};
    vecs[9]  = '{2'b01, 12'hF11, 32'h00000001, 12'hF11, 32'h00000000, 1'b0};
    vecs[10] = '{2'b01, 12'h320, 32'hFFFFFFFF, 12'h320, 32'h0000007D, 1'b0};
    vecs[11] = '{2'b01, 12'h320, 32'h00000000, 12'h320, 32'h00000000, 1'b0};
    vecs[12] = '{2'b01, 12'h342, 32'hDEADBEEF, 12'h342, 32'hDEADBEEF, 1'b0};
    vecs[13] = '{2'b01, 12'h343, 32'h0BADF00D, 12'h343, 32'h0BADF00D, 1'b0};
    vecs[14] = '{2'b00, 12'h000, 32'h00000000, 12'h7C0, 32'h00000000, 1'b1};
    vecs[15] = '{2'b00, 12'h000, 32'h00000000, 12'hB01, 32'h00000000, 1'b1};

    // Reset state
    #5;
    check_rd("rst_mstatus", 12'h300, 32'h00001800);
    check_rd("rst_misa", 12'h301, MISA_VALUE);
    check_rd("rst_mcycle", 12'hB00, 32'h0);
    check("rst_mtvecOut", mtvecOut, TRAP_VECTOR);
    check("rst_mepcOut", mepcOut, 32'h0);
    check("rst_pending", {31'b0, interruptPending}, 32'h0);
    tick();
    tick();
    check_rd("rst_mcycle_held", 12'hB00, 32'h0);
    reset = 1'b1;
    tick();
    check_rd("mcycle_first", 12'hB00, 32'h1);

    // Table-driven CSR write rules
    for (int i = 0; i < 16; i++) begin
      drive_write(vecs[i].op, vecs[i].waddr, vecs[i].wdata);
      tick();
      drive_write(2'b00, 12'h000, 32'h0);
      check_rd($sformatf("vec%0d_data", i), vecs[i].raddr, vecs[i].exp_data);
      check($sformatf("vec%0d_illegal", i), {31'b0, csrIllegal}, {31'b0, vecs[i].exp_ill});
    end

    // Write to read-only / unimplemented targets flags csrIllegal combinationally
    csrReadAddress = 12'h340;
    drive_write(2'b01, 12'hC00, 32'h1);
    #1;
    check("wr_ro_illegal", {31'b0, csrIllegal}, 32'h1);
    drive_write(2'b01, 12'h340, 32'h1);
    #1;
    check("wr_ok_legal", {31'b0, csrIllegal}, 32'h0);
    drive_write(2'b00, 12'h000, 32'h0);

    // mcycle high-half write across the 32-bit boundary
    drive_write(2'b01, 12'hB00, 32'hFFFFFFFF);
    tick();
    exp_mcycle = 64'h0000_0000_FFFF_FFFF;
    drive_write(2'b00, 12'h000, 32'h0);
    check_rd("mcyc_lo_set", 12'hB00, exp_mcycle[31:0]);
    check_rd("mcyc_hi_set", 12'hB80, exp_mcycle[63:32]);
    drive_write(2'b01, 12'hB80, 32'h0);
    tick();
    exp_mcycle = 64'h0000_0000_FFFF_FFFF;
    drive_write(2'b00, 12'h000, 32'h0);
    check_rd("mcyc_lo_hold", 12'hB00, 32'hFFFFFFFF);
    check_rd("mcyc_hi_hold", 12'hB80, 32'h0);
    tick();
    check_rd("mcyc_lo_wrap", 12'hB00, 32'h0);
    check_rd("mcyc_hi_wrap", 12'hB80, 32'h1);

    // minstret inhibit; mcycle keeps running
    retireCount = 2'd2;
    drive_write(2'b01, 12'h320, 32'h4);
    tick();
    drive_write(2'b00, 12'h000, 32'h0);
    check_rd("instret_before_inh", 12'hB02, 32'h2);
    for (int i = 0; i < 5; i++) tick();
    check_rd("instret_inhibited", 12'hB02, 32'h2);
    check_rd("mcyc_lo_inh", 12'hB00, exp_mcycle[31:0]);
    check_rd("mcyc_hi_inh", 12'hB80, exp_mcycle[63:32]);
    drive_write(2'b01, 12'h320, 32'h0);
    hpmEvent = 4'b0001;
    tick();
    drive_write(2'b00, 12'h000, 32'h0);
    check_rd("instret_clr_edge", 12'hB02, 32'h2);
    tick();
    check_rd("instret_plus2", 12'hB02, 32'h4);
    tick();
    check_rd("instret_plus4", 12'hB02, 32'h6);
    retireCount = 2'd0;
    hpmEvent    = 4'b0000;
    check_rd("hpm3_count", 12'hB03, 32'h3);
    check_rd("hpm4_idle", 12'hB04, 32'h0);

    // Interrupt pending, trap entry and mret
    drive_write(2'b01, 12'h300, 32'h8);
    tick();
    drive_write(2'b01, 12'h304, 32'h800);
    tick();
    drive_write(2'b00, 12'h000, 32'h0);
    #1;
    check("pending_no_irq", {31'b0, interruptPending}, 32'h0);
    externalInterrupt = 1'b1;
    #1;
    check("pending_irq", {31'b0, interruptPending}, 32'h1);
    check_rd("mip_meip", 12'h344, 32'h00000800);
    trapEnable = 1'b1;
    trapPC     = 32'h00001003;
    trapCause  = 32'h8000000B;
    trapValue  = 32'h00001234;
    tick();
    trapEnable = 1'b0;
    check("trap_mepcOut", mepcOut, 32'h00001000);
    check_rd("trap_mcause", 12'h342, 32'h8000000B);
    check_rd("trap_mtval", 12'h343, 32'h00001234);
    check_rd("trap_mstatus", 12'h300, 32'h00001880);
    check("trap_pending", {31'b0, interruptPending}, 32'h0);
    mretEnable = 1'b1;
    tick();
    mretEnable = 1'b0;
    check_rd("mret_mstatus", 12'h300, 32'h00001888);
    check("mret_pending", {31'b0, interruptPending}, 32'h1);

    // Trap, mret and a CSR write in the same cycle
    trapEnable = 1'b1;
    mretEnable = 1'b1;
    trapPC     = 32'h00002002;
    drive_write(2'b01, 12'h340, 32'h55);
    tick();
    trapEnable = 1'b0;
    mretEnable = 1'b0;
    drive_write(2'b00, 12'h000, 32'h0);
    check_rd("prio_mstatus", 12'h300, 32'h00001880);
    check_rd("prio_mscratch", 12'h340, 32'h12340078);
    check("prio_mepcOut", mepcOut, 32'h00002000);
    check_rd("illegal_7c0_data", 12'h7C0, 32'h0);
    check("illegal_7c0_flag", {31'b0, csrIllegal}, 32'h1);

    // Asynchronous reset mid-cycle
    reset = 1'b0;
    #1;
    check_rd("arst_mscratch", 12'h340, 32'h0);
    check_rd("arst_mcycle", 12'hB00, 32'h0);
    check_rd("arst_mstatus", 12'h300, 32'h00001800);
    check("arst_mepcOut", mepcOut, 32'h0);
    check("arst_pending", {31'b0, interruptPending}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
